ips2l_pcie_dma_mwr_sched: RTL

- Sequences device-to-host memory-write DMA. Accepts one command (host address and total DW length) and splits it into TLP-sized read requests for the BAR read controller.
- Each request respects the max payload size and never crosses a 4 KB boundary.
- Drives the controller's level-sensitive rd_en / rd_length / rd_addr, and waits for the controller's last-data flag before issuing the next request.

---
 rtl/ips2l_pcie_dma_mwr_sched_if.sv | 38 +++
 rtl/ips2l_pcie_dma_mwr_sched.sv | 135 +++++++++++++
 2 files changed

// File: rtl/ips2l_pcie_dma_mwr_sched_if.sv
// Command and read-request signals between the memory-write DMA scheduler
// and its neighbours (command source and BAR read controller).
interface ips2l_pcie_dma_mwr_sched_if #(
  parameter int LEN_WIDTH = 16
);
  logic                 i_cmd_valid;
  logic                 o_cmd_ready;
  logic [63:0]          i_cmd_addr;
  logic [LEN_WIDTH-1:0] i_cmd_len;
  logic                 o_rd_en;
  logic [9:0]           o_rd_length;
  logic [63:0]          o_rd_addr;
  logic                 i_last_data;

  // Scheduler side
  modport master (
    input  i_cmd_valid,
    input  i_cmd_addr,
    input  i_cmd_len,
    input  i_last_data,
    output o_cmd_ready,
    output o_rd_en,
    output o_rd_length,
    output o_rd_addr
  );

  // Command source / read controller side
  modport slave (
    output i_cmd_valid,
    output i_cmd_addr,
    output i_cmd_len,
    output i_last_data,
    input  o_cmd_ready,
    input  o_rd_en,
    input  o_rd_length,
    input  o_rd_addr
  );
endinterface

// File: rtl/ips2l_pcie_dma_mwr_sched.sv
// Splits one device-to-host write command into read requests that respect
// the max payload size and never cross a 4 KB host address boundary.
module ips2l_pcie_dma_mwr_sched #(
  parameter int LEN_WIDTH = 16,
  parameter int CNT_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  ips2l_pcie_dma_mwr_sched_if.master    bus,
  input  logic [2:0]                    i_mps,
  input  logic                          i_abort,
  output logic                          o_busy,
  output logic                          o_done,
  output logic [CNT_WIDTH-1:0]          o_tlp_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_ISSUE,
    ST_DONE
  } state_t;

  // Compare width wide enough for both the remaining count and a 1024-DW limit
  localparam int CW = (LEN_WIDTH > 11) ? LEN_WIDTH : 11;

  state_t               state_q, state_d;
  logic [63:0]          addr_q, addr_d;
  logic [LEN_WIDTH-1:0] rem_q, rem_d;
  logic [2:0]           mps_q, mps_d;
  logic [9:0]           len_q, len_d;
  logic                 rd_en_q, rd_en_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic [1:0]           mps_clamp;
  logic [10:0]          mps_dw;
  logic [10:0]          bnd_dw;
  logic [10:0]          lim_dw;
  logic [CW-1:0]        rem_w;
  logic [9:0]           tlp_len;
  logic                 tlp_is_last;

  // Size of the next TLP: smallest of remaining, payload limit and 4 KB distance
  always_comb begin
    mps_clamp = (mps_q > 3'd3) ? 2'd3 : mps_q[1:0];
    mps_dw    = 11'd32 << mps_clamp;
    bnd_dw    = 11'd1024 - {1'b0, addr_q[11:2]};
    lim_dw    = (mps_dw < bnd_dw) ? mps_dw : bnd_dw;
    rem_w     = CW'(rem_q);
    tlp_len   = (rem_w < CW'(lim_dw)) ? rem_w[9:0] : lim_dw[9:0];
  end

  assign tlp_is_last = (rem_q == LEN_WIDTH'(len_q));

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    mps_d   = mps_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    rd_en_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.i_cmd_valid) begin
          addr_d  = bus.i_cmd_addr & ~64'd3;
          rem_d   = bus.i_cmd_len;
          mps_d   = i_mps;
          cnt_d   = '0;
          state_d = (bus.i_cmd_len == '0) ? ST_DONE : ST_CALC;
        end
      end
      ST_CALC: begin
        len_d   = tlp_len;
        cnt_d   = cnt_q + CNT_WIDTH'(1);
        state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (bus.i_last_data) begin
          addr_d  = addr_q + {52'd0, len_q, 2'b00};
          rem_d   = rem_q - LEN_WIDTH'(len_q);
          state_d = tlp_is_last ? ST_DONE : ST_CALC;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort discards whatever the current state was about to commit
    if (i_abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      rem_d   = '0;
      addr_d  = addr_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
    end

    // Request level follows the state so it drops between TLPs
    rd_en_d = (state_d == ST_ISSUE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      mps_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      rd_en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      mps_q   <= mps_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      rd_en_q <= rd_en_d;
    end
  end

  assign bus.o_cmd_ready = (state_q == ST_IDLE);
  assign bus.o_rd_en     = rd_en_q;
  assign bus.o_rd_length = len_q;
  assign bus.o_rd_addr   = addr_q;
  assign o_busy          = (state_q != ST_IDLE);
  assign o_done          = (state_q == ST_DONE);
  assign o_tlp_cnt       = cnt_q;

endmodule
